fifo_rd_sched: RTL and testbench

Read-side scheduler that shares the single read port of the asynchronous FIFO among NREQ consumers in the read clock domain. It arbitrates round-robin, grants one consumer at a time for a bounded burst, and drives the FIFO read-increment from the winner's handshake. FIFO data is forwarded to all consumers on a shared bus. A one-hot valid qualifies the data for the owner only.

---
 rtl/fifo_rd_sched.sv | 126 ++++++++++++
 tb/tb_fifo_rd_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_sched.sv
// Read-side scheduler: round-robin shares one show-ahead FIFO read port among NREQ consumers.
// Latency: grant registered one edge after a request is seen in IDLE; data and pop are combinational in BURST.
// Backpressure: owner's rd_ready gates the pop; stalled grants are revoked after TIMEOUT cycles.
//
// Ports:
//   rclk, rst          read-domain clock, asynchronous active-high reset
//   fifo_empty         FIFO empty flag (registered in the FIFO)
//   fifo_rdata         FIFO head word, valid while fifo_empty is low
//   fifo_rinc          pop strobe to the FIFO (combinational)
//   req, rd_ready      per-consumer request level and ready
//   gnt                registered one-hot grant
//   dout, dout_valid   shared data bus and per-consumer one-hot valid
module fifo_rd_sched #(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                  rclk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_rinc,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       rd_ready,
   output logic [NREQ-1:0]       gnt,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [NREQ-1:0]       dout_valid
);

   localparam int             IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW-1:0]  LAST_IDX   = IW'(NREQ - 1);
   localparam logic [7:0]     BEAT_LAST  = 8'(MAX_BURST - 1);
   localparam logic [7:0]     STALL_LAST = 8'(TIMEOUT - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] lw_q, lw_d;
   logic [7:0]    beat_q, beat_d;
   logic [7:0]    stall_q, stall_d;

   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] scan;
   logic [NREQ-1:0] owner_oh;
   logic          in_burst;
   logic          pop;

   // Round-robin search starting just after the last winner, so the previous
   // owner is considered last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = lw_q;
      scan      = lw_q;
      for (int i = 0; i < NREQ; i++) begin
         scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
         if (!win_found && req[scan]) begin
            win_found = 1'b1;
            win_idx   = scan;
         end
      end
   end

   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
   end

   assign in_burst   = (state_q == BURST);
   assign pop        = in_burst & req[owner_q] & rd_ready[owner_q] & ~fifo_empty;
   assign fifo_rinc  = pop;
   assign gnt        = in_burst ? owner_oh : '0;
   assign dout_valid = gnt & {NREQ{~fifo_empty}};
   assign dout       = fifo_rdata;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      lw_d    = lw_q;
      beat_d  = beat_q;
      stall_d = stall_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               owner_d = win_idx;
               lw_d    = win_idx;
               beat_d  = '0;
               stall_d = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            if (!req[owner_q]) begin
               state_d = IDLE;
            end else if (pop) begin
               beat_d  = beat_q + 8'd1;
               stall_d = '0;
               if (beat_q == BEAT_LAST) state_d = IDLE;
            end else begin
               stall_d = stall_q + 8'd1;
               if (stall_q == STALL_LAST) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         lw_q    <= LAST_IDX;
         beat_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         lw_q    <= lw_d;
         beat_q  <= beat_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Testbench for fifo_rd_sched: table-driven cycle vectors plus directed corner sequences.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: exercised through rd_ready, req drop and fifo_empty stimulus.
module tb_fifo_rd_sched;

   logic       rclk;
   logic       rst;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;
   logic       fifo_rinc;
   logic [3:0] req;
   logic [3:0] rd_ready;
   logic [3:0] gnt;
   logic [7:0] dout;
   logic [3:0] dout_valid;

   int n_cmp;
   int n_err;

   // small FIFO occupancy model used by the single-consumer sequence
   logic model_on;
   int   cnt;
   logic [7:0] head;
   logic rinc_s;

   typedef struct {
      logic [3:0] req;
      logic [3:0] rdy;
      logic       empty;
      logic [3:0] e_gnt;
      logic       e_rinc;
      logic [3:0] e_dv;
   } vec_t;

   vec_t tbl [23];

   fifo_rd_sched #(.NREQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .TIMEOUT(15)) dut (
      .rclk       (rclk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rinc  (fifo_rinc),
      .req        (req),
      .rd_ready   (rd_ready),
      .gnt        (gnt),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic to_sample;
      @(negedge rclk);
   endtask

   task automatic to_drive;
      rinc_s = fifo_rinc;
      @(posedge rclk);
      #1;
      if (model_on) begin
         if (rinc_s && cnt > 0) begin
            cnt  = cnt - 1;
            head = head + 8'd1;
         end
         fifo_empty = (cnt == 0);
         fifo_rdata = head;
      end
   endtask

   task automatic apply_reset;
      rst        = 1'b1;
      model_on   = 1'b0;
      req        = '0;
      rd_ready   = '0;
      fifo_empty = 1'b1;
      @(posedge rclk);
      @(posedge rclk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_g;
      logic       exp_r;
      logic [3:0] exp_dv;
      int         pops;
      int         n_rinc;

      n_cmp = 0;
      n_err = 0;
      model_on = 1'b0;
      cnt = 0;
      head = '0;
      rinc_s = 1'b0;

      // ------------------------------------------------ vector table
      tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
      tbl[1]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[2]  = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0001};
      tbl[3]  = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0001};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0001};
      tbl[5]  = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0001};
      tbl[6]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[7]  = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 4'b0010};
      tbl[8]  = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 4'b0010};
      tbl[9]  = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 4'b0010};
      tbl[10] = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 4'b0010};
      tbl[11] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[12] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, 4'b0000};
      tbl[13] = '{4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b1, 4'b0100};
      tbl[14] = '{4'b1011, 4'b1111, 1'b0, 4'b0100, 1'b0, 4'b0100};
      tbl[15] = '{4'b1011, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[16] = '{4'b1011, 4'b1111, 1'b0, 4'b1000, 1'b1, 4'b1000};
      tbl[17] = '{4'b1011, 4'b0111, 1'b0, 4'b1000, 1'b0, 4'b1000};
      tbl[18] = '{4'b1011, 4'b1111, 1'b0, 4'b1000, 1'b1, 4'b1000};
      tbl[19] = '{4'b1011, 4'b1111, 1'b0, 4'b1000, 1'b1, 4'b1000};
      tbl[20] = '{4'b1011, 4'b1111, 1'b0, 4'b1000, 1'b1, 4'b1000};
      tbl[21] = '{4'b1011, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[22] = '{4'b1011, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0001};

      // ------------------------------------------------ reset state
      rst        = 1'b1;
      req        = 4'b1111;
      rd_ready   = 4'b1111;
      fifo_empty = 1'b0;
      fifo_rdata = 8'hA5;
      #2;
      chk("reset gnt", 32'(gnt), 32'h0);
      chk("reset dout_valid", 32'(dout_valid), 32'h0);
      chk("reset fifo_rinc", 32'(fifo_rinc), 32'h0);
      chk("reset dout", 32'(dout), 32'hA5);

      // ------------------------------------------------ table run
      apply_reset();
      for (int i = 0; i < 23; i++) begin
         req        = tbl[i].req;
         rd_ready   = tbl[i].rdy;
         fifo_empty = tbl[i].empty;
         to_sample();
         chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
         chk($sformatf("row%0d rinc", i), 32'(fifo_rinc), 32'(tbl[i].e_rinc));
         chk($sformatf("row%0d dout_valid", i), 32'(dout_valid), 32'(tbl[i].e_dv));
         to_drive();
      end

      // ------------------------------------------------ single consumer, 10 words
      apply_reset();
      model_on   = 1'b1;
      cnt        = 10;
      head       = 8'h10;
      fifo_rdata = head;
      fifo_empty = 1'b0;
      req        = 4'b0100;
      rd_ready   = 4'b0100;
      pops       = 0;
      n_rinc     = 0;
      for (int c = 0; c < 14; c++) begin
         to_sample();
         exp_g = ((c % 5) == 0) ? 4'b0000 : 4'b0100;
         exp_r = ((c % 5) != 0) && (pops < 10);
         chk($sformatf("single c%0d gnt", c), 32'(gnt), 32'(exp_g));
         chk($sformatf("single c%0d rinc", c), 32'(fifo_rinc), 32'(exp_r));
         chk($sformatf("single c%0d dout", c), 32'(dout), 32'(8'h10 + 8'(pops)));
         if (fifo_rinc) n_rinc++;
         if (exp_r) pops++;
         to_drive();
      end
      chk("single total pops", 32'(n_rinc), 32'd10);
      model_on = 1'b0;

      // ------------------------------------------------ timeout, consumer 1 never ready
      apply_reset();
      fifo_empty = 1'b0;
      fifo_rdata = 8'h33;
      req        = 4'b1010;
      rd_ready   = 4'b0000;
      for (int c = 0; c < 18; c++) begin
         to_sample();
         if (c == 0 || c == 16) exp_g = 4'b0000;
         else if (c <= 15)      exp_g = 4'b0010;
         else                   exp_g = 4'b1000;
         chk($sformatf("timeout c%0d gnt", c), 32'(gnt), 32'(exp_g));
         chk($sformatf("timeout c%0d rinc", c), 32'(fifo_rinc), 32'h0);
         to_drive();
      end

      // ------------------------------------------------ empty FIFO, word lands in stall cycle 5
      apply_reset();
      req      = 4'b0001;
      rd_ready = 4'b0001;
      for (int c = 0; c < 22; c++) begin
         fifo_empty = (c == 5) ? 1'b0 : 1'b1;
         to_sample();
         exp_g  = (c == 0 || c == 21) ? 4'b0000 : 4'b0001;
         exp_r  = (c == 5);
         exp_dv = (c == 5) ? 4'b0001 : 4'b0000;
         chk($sformatf("empty c%0d gnt", c), 32'(gnt), 32'(exp_g));
         chk($sformatf("empty c%0d rinc", c), 32'(fifo_rinc), 32'(exp_r));
         chk($sformatf("empty c%0d dout_valid", c), 32'(dout_valid), 32'(exp_dv));
         to_drive();
      end

      // ------------------------------------------------ reset mid-burst after 2 pops
      apply_reset();
      req        = 4'b1111;
      rd_ready   = 4'b1111;
      fifo_empty = 1'b0;
      for (int c = 0; c < 3; c++) begin
         to_sample();
         if (c > 0) chk($sformatf("midrst pop c%0d", c), 32'(fifo_rinc), 32'h1);
         to_drive();
      end
      #1;
      chk("midrst pre gnt", 32'(gnt), 32'h1);
      rst = 1'b1;
      #1;
      chk("midrst gnt", 32'(gnt), 32'h0);
      chk("midrst dout_valid", 32'(dout_valid), 32'h0);
      chk("midrst rinc", 32'(fifo_rinc), 32'h0);
      @(posedge rclk);
      #1;
      rst = 1'b0;
      req = 4'b1010;
      to_sample();
      chk("postrst idle gnt", 32'(gnt), 32'h0);
      to_drive();
      to_sample();
      chk("postrst gnt", 32'(gnt), 32'b0010);
      chk("postrst rinc", 32'(fifo_rinc), 32'h1);
      to_drive();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
